// File: rtl/ysyx_23060136_ifu_fetch_pkg.sv
// Shared IFU fetch types (ysyx_23060136_IFU_PKG) plus the core-wide defaults that live in
// ysyx_23060136_DEFINES: BITS_W and PC_RST. Optional feature: YSYX_23060136_IFU_MISALIGN_EXC_EN.
`ifndef ysyx_23060136_BITS_W
`define ysyx_23060136_BITS_W 32
`endif
`ifndef ysyx_23060136_PC_RST
`define ysyx_23060136_PC_RST 32'h8000_0000
`endif

package ysyx_23060136_IFU_PKG;
  localparam int IFU_BITS_W = `ysyx_23060136_BITS_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DROP = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic [IFU_BITS_W-1:0] pc;
    logic [IFU_BITS_W-1:0] inst;
    logic                  fault;
    logic                  misalign;
  } ifu2_out_t;
endpackage

// File: rtl/ysyx_23060136_ifu_fetch_out_reg.sv
// One-entry IFU2 output register: flush beats load, load beats clear-by-consume.
module ysyx_23060136_ifu_out_reg
  import ysyx_23060136_IFU_PKG::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      flush,
  input  logic      load,
  input  ifu2_out_t load_data,
  input  logic      ready,
  output logic      valid,
  output ifu2_out_t data
);
  logic      valid_r;
  ifu2_out_t data_r;

  // Output entry update with flush > load > consume priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r <= 1'b0;
      data_r  <= '0;
    end else if (flush) begin
      valid_r <= 1'b0;
      data_r  <= '0;
    end else if (load) begin
      valid_r <= 1'b1;
      data_r  <= load_data;
    end else if (valid_r && ready) begin
      valid_r <= 1'b0;
      data_r  <= '0;
    end else begin
      valid_r <= valid_r;
      data_r  <= data_r;
    end
  end

  assign valid = valid_r;
  assign data  = data_r;
endmodule

// File: rtl/ysyx_23060136_ifu_fetch.sv
// IFU2: single-outstanding instruction fetch with redirect drop and PC-counter stall.
// Optional misaligned-PC exception: define YSYX_23060136_IFU_MISALIGN_EXC_EN.
module ysyx_23060136_ifu_fetch
  import ysyx_23060136_IFU_PKG::*;
#(
  parameter int BITS_W = `ysyx_23060136_BITS_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BITS_W-1:0] IFU1_pc,
  input  logic              IFU_flush,
  output logic              IFU_stallIF,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [BITS_W-1:0] mem_req_addr,
  input  logic              mem_rsp_valid,
  input  logic [BITS_W-1:0] mem_rsp_data,
  input  logic              mem_rsp_err,
  output logic              IFU2_valid,
  input  logic              IFU2_ready,
  output logic [BITS_W-1:0] IFU2_pc,
  output logic [BITS_W-1:0] IFU2_inst,
  output logic              IFU2_fault,
  output logic              IFU2_misalign
);
  fetch_state_t      state_r, state_nxt_s;
  logic              drop_pend_r, drop_pend_nxt_s;
  logic [BITS_W-1:0] req_addr_r;
  logic              out_valid_s, idle_go_s, mis_s, hs_s, load_s;
  ifu2_out_t         load_data_s, out_data_s;

  assign idle_go_s = (state_r == IDLE) && !IFU_flush && (!out_valid_s || IFU2_ready);
`ifdef YSYX_23060136_IFU_MISALIGN_EXC_EN
  assign mis_s = idle_go_s && (IFU1_pc[1:0] != 2'b00);
`else
  assign mis_s = 1'b0;
`endif
  assign hs_s   = (state_r == REQ) && mem_req_ready;
  assign load_s = ((state_r == WAIT) && mem_rsp_valid && !IFU_flush) || mis_s;

  // Load payload: a memory response, or a synthesized misaligned-PC fault.
  always_comb begin
    load_data_s = '{pc: req_addr_r, inst: mem_rsp_data, fault: mem_rsp_err, misalign: 1'b0};
    if (mis_s) begin
      load_data_s = '{pc: IFU1_pc, inst: {BITS_W{1'b0}}, fault: 1'b0, misalign: 1'b1};
    end else begin
      load_data_s = load_data_s;
    end
  end

  // Fetch FSM next-state; drop_pend remembers a redirect that hit an in-flight request.
  always_comb begin
    state_nxt_s     = state_r;
    drop_pend_nxt_s = drop_pend_r;
    case (state_r)
      IDLE: begin
        if (idle_go_s && !mis_s) state_nxt_s = REQ;
        else                     state_nxt_s = IDLE;
      end
      REQ: begin
        if (hs_s) begin
          state_nxt_s     = (drop_pend_r || IFU_flush) ? DROP : WAIT;
          drop_pend_nxt_s = drop_pend_r || IFU_flush;
        end else if (IFU_flush) begin
          drop_pend_nxt_s = 1'b1;
        end else begin
          state_nxt_s = REQ;
        end
      end
      WAIT: begin
        if (mem_rsp_valid) begin
          state_nxt_s = IDLE;
        end else if (IFU_flush) begin
          state_nxt_s     = DROP;
          drop_pend_nxt_s = 1'b1;
        end else begin
          state_nxt_s = WAIT;
        end
      end
      DROP: begin
        if (mem_rsp_valid) begin
          state_nxt_s     = IDLE;
          drop_pend_nxt_s = 1'b0;
        end else begin
          state_nxt_s = DROP;
        end
      end
      default: begin
        state_nxt_s     = IDLE;
        drop_pend_nxt_s = 1'b0;
      end
    endcase
  end

  // State, drop flag and the request address latched when leaving IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      drop_pend_r <= 1'b0;
      req_addr_r  <= {BITS_W{1'b0}};
    end else begin
      state_r     <= state_nxt_s;
      drop_pend_r <= drop_pend_nxt_s;
      if (idle_go_s && !mis_s) req_addr_r <= IFU1_pc;
      else                     req_addr_r <= req_addr_r;
    end
  end

  ysyx_23060136_ifu_out_reg u_out_reg (
    .clk       (clk),
    .rst       (rst),
    .flush     (IFU_flush),
    .load      (load_s),
    .load_data (load_data_s),
    .ready     (IFU2_ready),
    .valid     (out_valid_s),
    .data      (out_data_s)
  );

  // The PC counter moves once per accepted live request, on a misalign fault, and on every flush.
  assign IFU_stallIF   = !((hs_s && !drop_pend_r && !IFU_flush) || IFU_flush || mis_s);
  assign mem_req_valid = (state_r == REQ);
  assign mem_req_addr  = req_addr_r;
  assign IFU2_valid    = out_valid_s;
  assign IFU2_pc       = out_data_s.pc;
  assign IFU2_inst     = out_data_s.inst;
  assign IFU2_fault    = out_data_s.fault;
  assign IFU2_misalign = out_data_s.misalign;
endmodule

// File: tb/tb_ysyx_23060136_ifu_fetch.sv
// Directed bench for the IFU2 fetch stage with a PC counter, a memory model and a delivery scoreboard.
module tb_ysyx_23060136_ifu_fetch;
  localparam logic [31:0] PC0      = 32'h8000_0000;
  localparam logic [31:0] ERR_ADDR = 32'h8000_0008;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_r;
  logic        flush;
  logic [31:0] target;
  logic        stall;
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic        mem_vld_r, spur, rsp_valid, rsp_err_r;
  logic [31:0] rsp_data_r;
  logic        o_valid, idu_ready, o_fault, o_mis;
  logic [31:0] o_pc, o_inst;
  int          mem_lat;
  logic        pend_r;
  logic [31:0] pend_addr_r;
  int          pend_cnt_r;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  assign rsp_valid = mem_vld_r | spur;

  ysyx_23060136_ifu_fetch dut (
    .clk(clk), .rst(rst), .IFU1_pc(pc_r), .IFU_flush(flush), .IFU_stallIF(stall),
    .mem_req_valid(req_valid), .mem_req_ready(req_ready), .mem_req_addr(req_addr),
    .mem_rsp_valid(rsp_valid), .mem_rsp_data(rsp_data_r), .mem_rsp_err(rsp_err_r),
    .IFU2_valid(o_valid), .IFU2_ready(idu_ready), .IFU2_pc(o_pc), .IFU2_inst(o_inst),
    .IFU2_fault(o_fault), .IFU2_misalign(o_mis)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  // PC counter environment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        pc_r <= PC0;
    else if (flush) pc_r <= target;
    else if (!stall) pc_r <= pc_r + 32'd4;
  end

  // Memory: responds mem_lat cycles after the handshake cycle's following edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_vld_r <= 1'b0; pend_r <= 1'b0; pend_cnt_r <= 0;
      pend_addr_r <= 32'd0; rsp_data_r <= 32'd0; rsp_err_r <= 1'b0;
    end else begin
      mem_vld_r <= 1'b0;
      if (pend_r) begin
        if (pend_cnt_r == 0) begin
          mem_vld_r <= 1'b1; rsp_data_r <= mem_word(pend_addr_r);
          rsp_err_r <= (pend_addr_r == ERR_ADDR); pend_r <= 1'b0;
        end else begin
          pend_cnt_r <= pend_cnt_r - 1;
        end
      end
      if (req_valid && req_ready) begin
        if (mem_lat == 0) begin
          mem_vld_r <= 1'b1; rsp_data_r <= mem_word(req_addr);
          rsp_err_r <= (req_addr == ERR_ADDR);
        end else begin
          pend_r <= 1'b1; pend_addr_r <= req_addr; pend_cnt_r <= mem_lat - 1;
        end
      end
    end
  end

  // Scoreboard: the IDU must see consecutive PCs from the last redirect, each with its memory word.
  logic [31:0] exp_pc, h_pc, h_inst, r_addr;
  logic        hold_prev = 1'b0, req_prev = 1'b0, h_fault, m_mis;
  initial begin
    exp_pc = PC0;
    forever begin
      @(negedge clk); #3;
      if (rst) begin
        exp_pc = PC0; hold_prev = 1'b0; req_prev = 1'b0;
      end else begin
`ifndef YSYX_23060136_IFU_MISALIGN_EXC_EN
        check("misalign_tied0", {31'd0, o_mis}, 32'd0);
`endif
        check("single_issue", {31'd0, o_valid && req_valid}, 32'd0);
        if (hold_prev) begin
          check("hold_valid", {31'd0, o_valid}, 32'd1);
          check("hold_pc", o_pc, h_pc);
          check("hold_inst", o_inst, h_inst);
          check("hold_fault", {31'd0, o_fault}, {31'd0, h_fault});
        end
        if (req_prev) begin
          check("req_kept", {31'd0, req_valid}, 32'd1);
          check("req_addr_stable", req_addr, r_addr);
        end
        if (flush) begin
          exp_pc = target;
        end else if (o_valid && idu_ready) begin
`ifdef YSYX_23060136_IFU_MISALIGN_EXC_EN
          m_mis = (exp_pc[1:0] != 2'b00);
`else
          m_mis = 1'b0;
`endif
          check("sb_pc", o_pc, exp_pc);
          check("sb_inst", o_inst, m_mis ? 32'd0 : mem_word(exp_pc));
          check("sb_fault", {31'd0, o_fault}, {31'd0, !m_mis && exp_pc == ERR_ADDR});
          check("sb_misalign", {31'd0, o_mis}, {31'd0, m_mis});
          exp_pc = exp_pc + 32'd4;
        end
        hold_prev = o_valid && !idu_ready && !flush;
        h_pc = o_pc; h_inst = o_inst; h_fault = o_fault;
        req_prev = req_valid && !req_ready;
        r_addr = req_addr;
      end
    end
  end

  int stall_low;
  initial begin
    rst = 1'b1; flush = 1'b0; target = 32'd0; req_ready = 1'b1; idu_ready = 1'b1;
    spur = 1'b0; mem_lat = 0; stall_low = 0;
    tick; #1;
    check("rst_req_valid", {31'd0, req_valid}, 32'd0);
    check("rst_req_addr", req_addr, 32'd0);
    check("rst_valid", {31'd0, o_valid}, 32'd0);
    check("rst_pc", o_pc, 32'd0);
    check("rst_inst", o_inst, 32'd0);
    check("rst_fault", {31'd0, o_fault}, 32'd0);
    check("rst_misalign", {31'd0, o_mis}, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd1);

    // Zero-wait streaming: request t+1, valid t+3, one PC step per fetch.
    tick; rst = 1'b0; #1;
    check("t0_stall", {31'd0, stall}, 32'd1);
    for (int k = 0; k < 9; k++) begin
      tick; #1;
      if (!stall) stall_low++;
      check("zw_req_valid", {31'd0, req_valid}, {31'd0, (k % 3) == 0});
      check("zw_out_valid", {31'd0, o_valid}, {31'd0, (k % 3) == 2});
      if ((k % 3) == 0) check("zw_req_addr", req_addr, PC0 + 32'(4 * (k / 3)));
      if ((k % 3) == 2) begin
        check("zw_pc", o_pc, PC0 + 32'(4 * (k / 3)));
        check("zw_fault", {31'd0, o_fault}, {31'd0, k == 8});
      end
      if (k == 2) check("zw_inst_lit", o_inst, 32'h9357_9BDF);
    end
    check("zw_stall_low_cnt", 32'(stall_low), 32'd3);

    // Memory not ready for 4 cycles.
    req_ready = 1'b0;
    for (int j = 0; j < 4; j++) begin
      tick; #1;
      check("nr_req_valid", {31'd0, req_valid}, 32'd1);
      check("nr_req_addr", req_addr, 32'h8000_000C);
      check("nr_stall", {31'd0, stall}, 32'd1);
    end
    tick; req_ready = 1'b1; #1;
    check("nr_hs_stall", {31'd0, stall}, 32'd0);
    tick; idu_ready = 1'b0;

    // IDU back-pressure: output held, no new request.
    for (int j = 0; j < 4; j++) begin
      tick; #1;
      check("bp_valid", {31'd0, o_valid}, 32'd1);
      check("bp_pc", o_pc, 32'h8000_000C);
      check("bp_inst_lit", o_inst, 32'h9357_9BD3);
      check("bp_no_req", {31'd0, req_valid}, 32'd0);
      check("bp_stall", {31'd0, stall}, 32'd1);
    end
    tick; idu_ready = 1'b1; #1;
    check("bp_release_stall", {31'd0, stall}, 32'd1);
    tick; #1;
    check("bp_next_req", {31'd0, req_valid}, 32'd1);
    check("bp_next_addr", req_addr, 32'h8000_0010);
    check("bp_consumed", {31'd0, o_valid}, 32'd0);

    // Flush in WAIT (response in the same cycle) is discarded.
    tick; flush = 1'b1; target = 32'h8000_0100; #1;
    check("fw_stall", {31'd0, stall}, 32'd0);
    tick; flush = 1'b0; #1;
    check("fw_no_valid", {31'd0, o_valid}, 32'd0);
    check("fw_idle", {31'd0, req_valid}, 32'd0);
    tick; #1;
    check("fw_req_addr", req_addr, 32'h8000_0100);
    tick;
    tick; #1;
    check("fw_target_pc", o_pc, 32'h8000_0100);
    req_ready = 1'b0;

    // Flush in REQ without handshake, ready two cycles later: request dropped.
    tick; flush = 1'b1; target = 32'h8000_0200; #1;
    check("fr_addr", req_addr, 32'h8000_0104);
    check("fr_stall_flush", {31'd0, stall}, 32'd0);
    tick; flush = 1'b0; #1;
    check("fr_req_held", {31'd0, req_valid}, 32'd1);
    check("fr_stall_after", {31'd0, stall}, 32'd1);
    tick; req_ready = 1'b1; #1;
    check("fr_hs_dropped_stall", {31'd0, stall}, 32'd1);
    tick; #1;
    check("fr_drop_req", {31'd0, req_valid}, 32'd0);
    check("fr_drop_stall", {31'd0, stall}, 32'd1);
    tick; #1;
    check("fr_no_valid", {31'd0, o_valid}, 32'd0);
    mem_lat = 2;
    tick; #1;
    check("fr_target_req", req_addr, 32'h8000_0200);
    check("fr_target_stall", {31'd0, stall}, 32'd0);

    // Flush in WAIT with no response yet: late response must be dropped.
    tick; flush = 1'b1; target = 32'h8000_0300; #1;
    check("fd_stall", {31'd0, stall}, 32'd0);
    tick; flush = 1'b0; #1;
    check("fd_stall_drop", {31'd0, stall}, 32'd1);
    tick; mem_lat = 0; #1;
    check("fd_late_rsp", {31'd0, rsp_valid}, 32'd1);
    check("fd_no_valid", {31'd0, o_valid}, 32'd0);
    tick; #1;
    check("fd_idle_no_valid", {31'd0, o_valid}, 32'd0);
    tick; #1;
    check("fd_req_addr", req_addr, 32'h8000_0300);

    // Reset mid-fetch.
    rst = 1'b1; #1;
    check("mr_req_valid", {31'd0, req_valid}, 32'd0);
    check("mr_req_addr", req_addr, 32'd0);
    check("mr_stall", {31'd0, stall}, 32'd1);

    // Spurious responses in IDLE/REQ are ignored; then redirect to a misaligned PC.
    tick; rst = 1'b0; req_ready = 1'b0; spur = 1'b1; #1;
    check("sp_idle", {31'd0, req_valid}, 32'd0);
    tick; #1;
    check("sp_req_addr", req_addr, PC0);
    tick; spur = 1'b0; flush = 1'b1; target = 32'h8000_0002; #1;
    check("sp_ignored", {31'd0, o_valid}, 32'd0);
    tick; flush = 1'b0; req_ready = 1'b1; #1;
    check("ma_drop_stall", {31'd0, stall}, 32'd1);
    tick;
    tick; #1;
`ifdef YSYX_23060136_IFU_MISALIGN_EXC_EN
    check("ma_stall", {31'd0, stall}, 32'd0);
    check("ma_no_req", {31'd0, req_valid}, 32'd0);
    tick; #1;
    check("ma_valid", {31'd0, o_valid}, 32'd1);
    check("ma_flag", {31'd0, o_mis}, 32'd1);
    check("ma_inst", o_inst, 32'd0);
    check("ma_pc", o_pc, 32'h8000_0002);
    check("ma_no_req2", {31'd0, req_valid}, 32'd0);
`else
    check("ma_stall", {31'd0, stall}, 32'd1);
    tick; #1;
    check("ma_req", {31'd0, req_valid}, 32'd1);
    check("ma_addr_asis", req_addr, 32'h8000_0002);
    tick;
    tick; #1;
    check("ma_pc", o_pc, 32'h8000_0002);
    check("ma_flag", {31'd0, o_mis}, 32'd0);
`endif
    for (int j = 0; j < 4; j++) tick;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
